// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit common-anode 7-segment driver with frame-synchronous value update
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   logic [PW-1:0]       r_pcnt;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_shadow_val, r_disp_val;
   logic [DIGITS-1:0]   r_shadow_dp, r_disp_dp, w_blank;
   logic                r_pend, w_tick, w_wrap, w_hi_zero;
   logic [3:0]          w_nib;
   logic [6:0]          w_seg_on;
   assign w_tick = en && (r_pcnt == PW'(REFRESH_DIV - 1));
   assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));
   assign w_nib  = r_disp_val[4*r_idx +: 4];
   // Blank mask: walk down from the top digit while nibbles stay zero; digit 0 is never blanked
   always_comb begin
      w_hi_zero = 1'b1;
      w_blank   = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         w_hi_zero  = w_hi_zero && (r_disp_val[4*k +: 4] == 4'h0);
         w_blank[k] = w_hi_zero;
      end
   end
   // Active-high segment set {g,f,e,d,c,b,a} for the selected nibble
   always_comb begin
      case (w_nib)
         4'h0:    w_seg_on = 7'h3F;
         4'h1:    w_seg_on = 7'h06;
         4'h2:    w_seg_on = 7'h5B;
         4'h3:    w_seg_on = 7'h4F;
         4'h4:    w_seg_on = 7'h66;
         4'h5:    w_seg_on = 7'h6D;
         4'h6:    w_seg_on = 7'h7D;
         4'h7:    w_seg_on = 7'h07;
         4'h8:    w_seg_on = 7'h7F;
         4'h9:    w_seg_on = 7'h6F;
         4'hA:    w_seg_on = 7'h77;
         4'hB:    w_seg_on = 7'h7C;
         4'hC:    w_seg_on = 7'h39;
         4'hD:    w_seg_on = 7'h5E;
         4'hE:    w_seg_on = 7'h79;
         default: w_seg_on = 7'h71;
      endcase
   end
   // Refresh prescaler and digit index; both hold while disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
         r_idx  <= '0;
      end else if (en) begin
         r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
         r_idx  <= w_wrap ? '0 : (w_tick ? r_idx + 1'b1 : r_idx);
      end
   end
   // Double buffer: loads park in the shadow until the frame boundary; a load on the boundary goes straight to display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
         r_pend       <= 1'b0;
      end else begin
         if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_in;
         end
         if (w_wrap && load) begin
            r_disp_val <= value;
            r_disp_dp  <= dp_in;
         end else if (w_wrap && r_pend) begin
            r_disp_val <= r_shadow_val;
            r_disp_dp  <= r_shadow_dp;
         end
         r_pend <= w_wrap ? 1'b0 : (r_pend || load);
      end
   end
   // Registered pin drive from the pre-edge scan state; anodes stay dark while pcnt is 0 to avoid ghosting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg   <= 7'h7F;
         dp    <= 1'b1;
         an    <= '1;
         frame <= 1'b0;
      end else begin
         seg   <= (lz_blank && w_blank[r_idx]) ? 7'h7F : ~w_seg_on;
         dp    <= ~r_disp_dp[r_idx];
         an    <= (en && r_pcnt != '0) ? ~(DIGITS'(1) << r_idx) : '1;
         frame <= w_wrap;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4
module tb_seg7_scan_driver;
   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lz_blank = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame;
   int          checks = 0, fails = 0, pos = 0;
   logic [15:0] e_disp = '0, e_next = '0;
   logic [3:0]  e_dpd = '0, e_dpn = '0;
   logic [12:0] sb[$];
   logic [12:0] got, exp_v;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
      .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an), .frame(frame)
   );

   always #5 clk = ~clk;

   // Expected pins after the coming edge: pos is the 16-step scan position, e_disp the displayed value
   function automatic logic [12:0] expect_out();
      int d;
      logic [3:0] nib;
      logic [6:0] s;
      d   = pos / 4;
      nib = e_disp[4*d +: 4];
      s   = (lz_blank && d != 0 && (e_disp >> (4*d)) == 16'h0) ? 7'h7F : seg_tab[nib];
      return {(en && pos % 4 != 0) ? ~(4'b0001 << d) : 4'hF, s, ~e_dpd[d], en && pos == 15};
   endfunction

   // One clock; advance the scan position and apply the frame-boundary transfer
   task automatic tick();
      @(posedge clk);
      #1;
      if (en && !rst) begin
         if (pos == 15) begin
            e_disp = e_next;
            e_dpd  = e_dpn;
         end
         pos = (pos + 1) % 16;
      end
      load = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load   = 1'b1;
      value  = v;
      dp_in  = d;
      e_next = v;
      e_dpn  = d;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({an, seg, dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_hold: got an=%h seg=%h dp=%b frame=%b, expected an=f seg=7f dp=1 frame=0", an, seg, dp, frame);
      end
      rst = 1'b0;
      en  = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) do_load(16'h8888, 4'hF);
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL reset_start c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_async: got an=%h seg=%h dp=%b frame=%b, expected an=f seg=7f dp=1 frame=0", an, seg, dp, frame);
      end
      tick();
      pos = 0;
      e_disp = '0;
      e_next = '0;
      e_dpd = '0;
      e_dpn = '0;
      rst = 1'b0;
      for (int c = 0; c < 32; c++) begin
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL reset_frame c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_scan_order();
      for (int c = 0; c < 34; c++) begin
         if (c == 0) do_load(16'h1234, 4'h0);
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL scan_order c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_double_buffer();
      for (int c = 0; c < 36; c++) begin
         if (c == 3) do_load(16'hABCD, 4'b0101);
         if (c == 5) do_load(16'hEF01, 4'b1010);
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL double_buffer c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_boundary_load();
      for (int c = 0; c < 20; c++) begin
         if (pos == 15) do_load(16'h0008, 4'h0);
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL boundary_load c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_lz_blank();
      lz_blank = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c == 0) do_load(16'h0050, 4'b1000);
         if (c == 30) lz_blank = 1'b0;
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL lz_blank c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_enable();
      for (int c = 0; c < 40; c++) begin
         en = !(c >= 8 && c < 18);
         if (c == 12) do_load(16'h5678, 4'b0011);
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL enable c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 40; c++) begin
         if (c < 24) do_load(16'(c * 16'h0123 + 16'h0F00), 4'(c));
         sb.push_back(expect_out());
         tick();
         got = {an, seg, dp, frame};
         exp_v = sb.pop_front();
         checks++;
         if (got !== exp_v) begin
            fails++;
            $display("FAIL back_to_back c=%0d: got an=%h seg=%h dp=%b frame=%b, expected an=%h seg=%h dp=%b frame=%b", c, got[12:9], got[8:2], got[1], got[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_double_buffer();
      test_boundary_load();
      test_lz_blank();
      test_enable();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "time limit");
   end
endmodule
